// File: rtl/rtc_pkg.sv
// Shared constants for the RTC time-of-day counter.
// Packed-BCD time word layout: {hh[23:16], mm[15:8], ss[7:0]}, each byte {tens, ones}.
package rtc_pkg;

    localparam int unsigned BcdW  = 4;
    localparam int unsigned TimeW = 24;

    // Bit offsets of the ones digit of each field; the tens digit sits BcdW above.
    localparam int unsigned SsLsb = 0;
    localparam int unsigned MmLsb = 8;
    localparam int unsigned HhLsb = 16;

    // Digit limits.
    localparam int unsigned OnesMax        = 9;
    localparam int unsigned TensMax        = 5;
    localparam int unsigned HourTensMax    = 2;
    localparam int unsigned HourOnesMaxTop = 3;

    localparam logic [TimeW-1:0] ResetTime = '0;

    // Extract one BCD digit whose least significant bit is at 'lsb'.
    function automatic logic [BcdW-1:0] digit_at(input logic [TimeW-1:0] t,
                                                 input int unsigned lsb);
        return t[lsb +: BcdW];
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit of the time-of-day carry chain.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset (digit -> 0)
//   inc_i            advance by one this cycle
//   load_i           load load_val_i (wins over inc_i)
//   load_val_i       value to load
//   wrap_to_zero_i   force the increment to wrap to 0 regardless of Max
//   digit_o          registered digit value
//   next_o           value the digit takes after this edge (ignores reset)
//   carry_o          increment while at Max; drives the next digit
module bcd_digit_counter
    import rtc_pkg::*;
#(
    parameter int unsigned Max = 9
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            load_i,
    input  logic [BcdW-1:0] load_val_i,
    input  logic            wrap_to_zero_i,
    output logic [BcdW-1:0] digit_o,
    output logic [BcdW-1:0] next_o,
    output logic            carry_o
);

    localparam logic [BcdW-1:0] MaxDigit = BcdW'(Max);

    logic [BcdW-1:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = load_val_i;
        end else if (inc_i) begin
            if (wrap_to_zero_i || digit_q == MaxDigit) begin
                digit_d = '0;
            end else begin
                digit_d = digit_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign next_o  = digit_d;
    assign carry_o = inc_i && (digit_q == MaxDigit);

endmodule

// File: rtl/rtc_time_counter.sv
// RTC time-of-day counter: packed-BCD hh:mm:ss, 24-hour, advanced by a 1 Hz strobe.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   tick_i           one-cycle 1 Hz strobe
//   set_en_i         one-cycle request to load set_time_i (validated)
//   set_time_i       packed-BCD time to load
//   alarm_load_i     one-cycle request to load alarm_time_i (validated)
//   alarm_time_i     packed-BCD alarm value
//   alarm_en_i       alarm matching enable (level)
//   time_bcd_o       current time
//   day_pulse_o      strobe on the HOUR_MAX:59:59 -> 00:00:00 rollover
//   alarm_o          strobe when a tick advances time onto the alarm value
//   set_err_o        strobe when a set or alarm load was rejected
module rtc_time_counter
    import rtc_pkg::*;
#(
    parameter int unsigned HOUR_MAX  = HourTensMax * 10 + HourOnesMaxTop,
    parameter bit          SET_CHECK = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             set_en_i,
    input  logic [TimeW-1:0] set_time_i,
    input  logic             alarm_load_i,
    input  logic [TimeW-1:0] alarm_time_i,
    input  logic             alarm_en_i,
    output logic [TimeW-1:0] time_bcd_o,
    output logic             day_pulse_o,
    output logic             alarm_o,
    output logic             set_err_o
);

    localparam int unsigned     NumDigits = TimeW / BcdW;
    localparam logic [BcdW-1:0] HhTensTop = BcdW'(HOUR_MAX / 10);
    localparam logic [BcdW-1:0] HhOnesTop = BcdW'(HOUR_MAX % 10);

    function automatic logic time_valid(input logic [TimeW-1:0] t);
        logic        ok;
        int unsigned hh;
        ok = 1'b1;
        for (int unsigned k = 0; k < NumDigits; k++) begin
            if (digit_at(t, k * BcdW) > BcdW'(OnesMax)) ok = 1'b0;
        end
        if (digit_at(t, SsLsb + BcdW) > BcdW'(TensMax)) ok = 1'b0;
        if (digit_at(t, MmLsb + BcdW) > BcdW'(TensMax)) ok = 1'b0;
        hh = 32'(digit_at(t, HhLsb + BcdW)) * 10 + 32'(digit_at(t, HhLsb));
        if (hh > HOUR_MAX) ok = 1'b0;
        return ok || !SET_CHECK;
    endfunction

    // Digit 0 is seconds ones, digit 5 is hours tens.
    logic [NumDigits-1:0][BcdW-1:0] digit, next;
    logic [NumDigits-1:0]           inc, carry;

    logic             set_ok, alarm_ok, set_load, advance, hh_top, day_wrap;
    logic [TimeW-1:0] alarm_q;
    logic             day_pulse_q, alarm_hit_q, set_err_q;

    assign set_ok   = time_valid(set_time_i);
    assign alarm_ok = time_valid(alarm_time_i);
    assign set_load = set_en_i && set_ok;
    // Any set request, accepted or not, swallows a coinciding tick.
    assign advance  = tick_i && !set_en_i;

    // Hours do not follow a plain decimal carry: at HOUR_MAX both hour digits wrap together.
    assign hh_top   = (digit[5] == HhTensTop) && (digit[4] == HhOnesTop);
    assign day_wrap = carry[3] && hh_top;

    always_comb begin
        inc    = '0;
        inc[0] = advance;
        for (int unsigned k = 1; k < 5; k++) begin
            inc[k] = carry[k-1];
        end
        inc[5] = carry[4] || day_wrap;
    end

    for (genvar i = 0; i < NumDigits; i++) begin : g_digit
        bcd_digit_counter #(
            .Max((i == 5) ? HOUR_MAX / 10 : (((i % 2) == 1) ? TensMax : OnesMax))
        ) u_digit (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .inc_i         (inc[i]),
            .load_i        (set_load),
            .load_val_i    (set_time_i[i*BcdW +: BcdW]),
            .wrap_to_zero_i((i >= 4) ? day_wrap : 1'b0),
            .digit_o       (digit[i]),
            .next_o        (next[i]),
            .carry_o       (carry[i])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alarm_q     <= ResetTime;
            day_pulse_q <= 1'b0;
            alarm_hit_q <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            if (alarm_load_i && alarm_ok) begin
                alarm_q <= alarm_time_i;
            end
            // The hours-tens carry only occurs on the midnight wrap.
            day_pulse_q <= carry[5];
            // While advancing no load is active, so 'next' is the incremented time.
            alarm_hit_q <= advance && alarm_en_i && (next == alarm_q);
            set_err_q   <= (set_en_i && !set_ok) || (alarm_load_i && !alarm_ok);
        end
    end

    assign time_bcd_o  = digit;
    assign day_pulse_o = day_pulse_q;
    assign alarm_o     = alarm_hit_q;
    assign set_err_o   = set_err_q;

endmodule
